// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: word width, I/O window
// layout and the write-strobe FSM encoding.
package data_mem_responder_pkg;

    localparam int WORD_W = 16;
    localparam int LED_W  = 10;
    localparam int SW_W   = 10;

    // Word offsets inside the 4-word I/O window
    localparam logic [1:0] IO_LED  = 2'd0;
    localparam logic [1:0] IO_SW   = 2'd1;
    localparam logic [1:0] IO_CYC  = 2'd2;
    localparam logic [1:0] IO_WCNT = 2'd3;

    // IDLE: armed for the next store edge; HOLD: store still high after a write
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } wr_state_t;

endpackage

// File: rtl/data_mem_responder_ram_sp_wf.sv
// Single-port, write-first, synchronous-read RAM. Contents are deliberately
// not reset so that data survives a processor reset.
module ram_sp_wf #(
    parameter int DEPTH_LOG2 = 7,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Write the addressed word and forward the new value to the read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the processor load/store interface: word-addressed data
// RAM plus a 4-word I/O window (LEDs, switches, cycle counter, write counter).
// Write data is the bus value captured one cycle before the store cycle, and a
// level-held store produces a single write per rising edge.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 7,
    parameter logic [15:0] IO_BASE    = 16'hFFF0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              store,
    input  logic [SW_W-1:0]   sw,
    output logic [WORD_W-1:0] rdata,
    output logic [LED_W-1:0]  leds,
    output logic              addr_err
);

    wr_state_t         state;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] cyc_cnt;
    logic [WORD_W-1:0] wr_cnt;
    logic [WORD_W-1:0] io_rdata_q;
    logic              rd_ram_q;
    logic [WORD_W-1:0] ram_rdata;

    logic              in_ram;
    logic              in_io;
    logic              unmapped;
    logic [1:0]        io_off;
    logic              do_write;
    logic              ram_we;
    logic              led_we;
    logic              cyc_clr;
    logic              wr_counted;
    logic [WORD_W-1:0] io_rd;

    // Address decode and write qualification for the current cycle
    always_comb begin
        in_ram     = (addr >> DEPTH_LOG2) == 16'd0;
        in_io      = (addr >= IO_BASE) && (addr <= (IO_BASE + 16'd3));
        unmapped   = !in_ram && !in_io;
        io_off     = addr[1:0] - IO_BASE[1:0];
        do_write   = (state == ST_IDLE) && store;
        ram_we     = do_write && in_ram;
        led_we     = do_write && in_io && (io_off == IO_LED);
        cyc_clr    = do_write && in_io && (io_off == IO_CYC);
        wr_counted = ram_we || led_we || cyc_clr;
    end

    // I/O read mux; a same-cycle write to the read word is shown write-first
    always_comb begin
        io_rd = '0;
        case (io_off)
            IO_LED:  io_rd = led_we ? {{(WORD_W-LED_W){1'b0}}, wdata_q[LED_W-1:0]}
                                    : {{(WORD_W-LED_W){1'b0}}, leds};
            IO_SW:   io_rd = {{(WORD_W-SW_W){1'b0}}, sw};
            IO_CYC:  io_rd = cyc_clr ? '0 : cyc_cnt;
            default: io_rd = wr_cnt;
        endcase
    end

    // Write FSM: one write per rising edge of store
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (store)  state <= ST_HOLD;
                ST_HOLD: if (!store) state <= ST_IDLE;
                default:             state <= ST_IDLE;
            endcase
        end
    end

    // Bus capture, I/O registers, counters and the sticky error flag
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wdata_q  <= '0;
            leds     <= '0;
            cyc_cnt  <= '0;
            wr_cnt   <= '0;
            addr_err <= 1'b0;
        end else begin
            wdata_q <= wdata;
            if (led_we)
                leds <= wdata_q[LED_W-1:0];
            if (cyc_clr)
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 16'd1;
            if (wr_counted)
                wr_cnt <= wr_cnt + 16'd1;
            if (unmapped)
                addr_err <= 1'b1;
        end
    end

    // Registered read source select; unmapped reads return zero
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_ram_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            rd_ram_q   <= in_ram;
            io_rdata_q <= in_io ? io_rd : '0;
        end
    end

    assign rdata = rd_ram_q ? ram_rdata : io_rdata_q;

    ram_sp_wf #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WORD_W)
    ) u_ram (
        .clk   (Clock),
        .we    (ram_we),
        .addr  (addr[DEPTH_LOG2-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder: RAM write/readback, stuck store,
// LED/switch I/O, cycle counter clear and wrap, unmapped access, reset mid-HOLD.
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic        Clock;
    logic        Resetn;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        store;
    logic [9:0]  sw;
    logic [15:0] rdata;
    logic [9:0]  leds;
    logic        addr_err;

    int n_cmp;
    int n_bad;

    data_mem_responder #(
        .DEPTH_LOG2 (7),
        .IO_BASE    (16'hFFF0)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .addr     (addr),
        .wdata    (wdata),
        .store    (store),
        .sw       (sw),
        .rdata    (rdata),
        .leds     (leds),
        .addr_err (addr_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Bus value one cycle, then a one-cycle store with the bus changed
    task automatic do_write(input logic [15:0] a, input logic [15:0] v);
        addr  = a;
        wdata = v;
        store = 1'b0;
        step();
        wdata = ~v;
        store = 1'b1;
        step();
        store = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        addr   = 16'hFFF3;
        wdata  = 16'h0000;
        store  = 1'b0;
        sw     = 10'h000;
        step();
        step();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata: got %h expected %h", rdata, 16'h0000); end
        n_cmp++;
        if (leds !== 10'h000) begin n_bad++; $display("FAIL reset_leds: got %h expected %h", leds, 10'h000); end
        n_cmp++;
        if (addr_err !== 1'b0) begin n_bad++; $display("FAIL reset_addr_err: got %b expected %b", addr_err, 1'b0); end
        Resetn = 1'b1;
        step();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_wcnt: got %h expected %h", rdata, 16'h0000); end
    endtask

    task automatic test_write_read();
        addr  = 16'd5;
        wdata = 16'h1234;
        store = 1'b0;
        step();
        wdata = 16'h0000;
        store = 1'b1;
        step();
        n_cmp++;
        if (rdata !== 16'h1234) begin n_bad++; $display("FAIL wr_write_first: got %h expected %h", rdata, 16'h1234); end
        store = 1'b0;
        step();
        n_cmp++;
        if (rdata !== 16'h1234) begin n_bad++; $display("FAIL wr_readback: got %h expected %h", rdata, 16'h1234); end
        addr = 16'hFFF3;
        step();
        n_cmp++;
        if (rdata !== 16'h0001) begin n_bad++; $display("FAIL wr_wcnt: got %h expected %h", rdata, 16'h0001); end
    endtask

    task automatic test_stuck_store();
        logic [15:0] bus_vals [4];
        bus_vals[0] = 16'h1111;
        bus_vals[1] = 16'h2222;
        bus_vals[2] = 16'h3333;
        bus_vals[3] = 16'h4444;
        addr  = 16'd6;
        wdata = 16'hAAAA;
        store = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            wdata = bus_vals[i];
            store = 1'b1;
            step();
        end
        store = 1'b0;
        step();
        n_cmp++;
        if (rdata !== 16'hAAAA) begin n_bad++; $display("FAIL stuck_readback: got %h expected %h", rdata, 16'hAAAA); end
        addr = 16'hFFF3;
        step();
        n_cmp++;
        if (rdata !== 16'h0002) begin n_bad++; $display("FAIL stuck_wcnt: got %h expected %h", rdata, 16'h0002); end
    endtask

    task automatic test_leds();
        do_write(16'hFFF0, 16'hFFFF);
        n_cmp++;
        if (leds !== 10'h3FF) begin n_bad++; $display("FAIL leds_out: got %h expected %h", leds, 10'h3FF); end
        addr = 16'hFFF0;
        step();
        n_cmp++;
        if (rdata !== 16'h03FF) begin n_bad++; $display("FAIL leds_read: got %h expected %h", rdata, 16'h03FF); end
        sw   = 10'h155;
        addr = 16'hFFF1;
        step();
        n_cmp++;
        if (rdata !== 16'h0155) begin n_bad++; $display("FAIL sw_read: got %h expected %h", rdata, 16'h0155); end
        // write to the read-only switch word: dropped, not counted
        do_write(16'hFFF1, 16'h0001);
        addr = 16'hFFF3;
        step();
        n_cmp++;
        if (rdata !== 16'h0003) begin n_bad++; $display("FAIL ro_write_wcnt: got %h expected %h", rdata, 16'h0003); end
        n_cmp++;
        if (leds !== 10'h3FF) begin n_bad++; $display("FAIL leds_hold: got %h expected %h", leds, 10'h3FF); end
    endtask

    task automatic test_counter();
        addr  = 16'hFFF2;
        wdata = 16'h0000;
        store = 1'b0;
        step();
        store = 1'b1;
        step();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL cyc_clear_same: got %h expected %h", rdata, 16'h0000); end
        store = 1'b0;
        step();
        step();
        step();
        n_cmp++;
        if (rdata !== 16'h0002) begin n_bad++; $display("FAIL cyc_after3: got %h expected %h", rdata, 16'h0002); end
        for (int i = 4; i <= 65536; i++) step();
        n_cmp++;
        if (rdata !== 16'hFFFF) begin n_bad++; $display("FAIL cyc_max: got %h expected %h", rdata, 16'hFFFF); end
        step();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL cyc_wrap: got %h expected %h", rdata, 16'h0000); end
        addr = 16'hFFF3;
        step();
        n_cmp++;
        if (rdata !== 16'h0004) begin n_bad++; $display("FAIL cyc_wcnt: got %h expected %h", rdata, 16'h0004); end
    endtask

    task automatic test_unmapped();
        do_write(16'd0, 16'h5A5A);
        n_cmp++;
        if (addr_err !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b expected %b", addr_err, 1'b0); end
        addr = 16'h0200;
        step();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL unmapped_read: got %h expected %h", rdata, 16'h0000); end
        n_cmp++;
        if (addr_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b expected %b", addr_err, 1'b1); end
        do_write(16'h0200, 16'hBEEF);
        addr = 16'd0;
        step();
        n_cmp++;
        if (rdata !== 16'h5A5A) begin n_bad++; $display("FAIL unmapped_no_alias: got %h expected %h", rdata, 16'h5A5A); end
        addr = 16'hFFF3;
        step();
        n_cmp++;
        if (rdata !== 16'h0005) begin n_bad++; $display("FAIL unmapped_wcnt: got %h expected %h", rdata, 16'h0005); end
        n_cmp++;
        if (addr_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b expected %b", addr_err, 1'b1); end
    endtask

    task automatic test_reset_mid();
        addr  = 16'd7;
        wdata = 16'hC3C3;
        store = 1'b0;
        step();
        store = 1'b1;
        wdata = 16'h0F0F;
        step();
        step();
        // FSM is in HOLD with store high; reset asynchronously
        Resetn = 1'b0;
        #1;
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_rdata: got %h expected %h", rdata, 16'h0000); end
        n_cmp++;
        if (leds !== 10'h000) begin n_bad++; $display("FAIL rst_mid_leds: got %h expected %h", leds, 10'h000); end
        n_cmp++;
        if (addr_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_err: got %b expected %b", addr_err, 1'b0); end
        step();
        step();
        // release with store still high: one write of the reset bus capture (0)
        wdata  = 16'h1357;
        Resetn = 1'b1;
        step();
        wdata = 16'h2468;
        step();
        store = 1'b0;
        step();
        n_cmp++;
        if (rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_rel_write: got %h expected %h", rdata, 16'h0000); end
        addr = 16'd5;
        step();
        n_cmp++;
        if (rdata !== 16'h1234) begin n_bad++; $display("FAIL ram_keep5: got %h expected %h", rdata, 16'h1234); end
        addr = 16'd6;
        step();
        n_cmp++;
        if (rdata !== 16'hAAAA) begin n_bad++; $display("FAIL ram_keep6: got %h expected %h", rdata, 16'hAAAA); end
        addr = 16'hFFF3;
        step();
        n_cmp++;
        if (rdata !== 16'h0001) begin n_bad++; $display("FAIL rst_rel_wcnt: got %h expected %h", rdata, 16'h0001); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_write_read();
        test_stuck_store();
        test_leds();
        test_counter();
        test_unmapped();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the processor's load/store interface: accepts the latched address, bus data and `store` strobe from the processor, and returns read data on the processor's `mem` input. It contains a word-addressed data RAM plus a small memory-mapped I/O window (LEDs, switches, cycle counter), and sits between the processor and the board I/O in the top level.

## Interface
- `DEPTH_LOG2`, 7: RAM holds 2^DEPTH_LOG2 16-bit words at addresses 0 .. 2^DEPTH_LOG2-1.
- `IO_BASE`, 16'hFFF0: base of the I/O window (4 words).

Ports:
- `Clock`  in  1  single clock, all state on rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `addr`  in  16  word address from the processor address register.
- `wdata`  in  16  processor bus (BusWires).
- `store`  in  1  write strobe (level, may stay high for several cycles).
- `sw`  in  10  board switches.
- `rdata`  out  16  read data, drives the processor's `mem` input.
- `leds`  out  10  LED register.
- `addr_err`  out  1  sticky out-of-range access flag.

## Operation
- Address decode: RAM if `addr < 2^DEPTH_LOG2`; IO if `IO_BASE <= addr <= IO_BASE+3`; anything else is unmapped.
- IO map: +0 LEDs (R/W, low 10 bits, upper bits read 0); +1 switches (R, zero-extended; writes ignored); +2 free-running cycle counter (R; any write clears it to 0); +3 write counter: number of accepted writes, mod 2^16 (R; writes ignored).
- Bus capture: `wdata` is registered every cycle into `wdata_q`. Write data is always `wdata_q`, i.e. the bus value of the cycle before the write cycle; the processor drives the register onto the bus one step before raising `store`.
- Write FSM (states IDLE, HOLD):
  - IDLE, `store`=1: perform the write (RAM word, LED register or counter clear), increment the write counter, go to HOLD.
  - HOLD, `store`=1: stay in HOLD, no write.
  - HOLD, `store`=0: go to IDLE.
  - A `store` held high produces exactly one write per rising edge of `store`.
- Writes to unmapped addresses or read-only IO words are dropped; the write counter still increments only for RAM, LED and counter-clear writes. Unmapped writes set `addr_err`.
- Reads are synchronous. Every cycle `rdata` <= the decoded word at the current `addr`. Unmapped reads return 16'h0000 and set `addr_err`.
- Write-first: if the cycle's write targets the address being read, `rdata` shows the new data.
- `addr_err` clears only on reset.
- RAM contents are not cleared by reset.

## Timing
- Reset values: `rdata`=0, `leds`=0, `addr_err`=0, `wdata_q`=0, cycle counter=0, write counter=0, FSM=IDLE.
- Read latency is 1 cycle: `addr` valid in processor step 2 gives `rdata` valid in step 3, when the processor muxes `mem` onto the bus.
- Write takes effect at the edge ending the first `store`-high cycle. A readback of that address issued in the next cycle returns the new value.
- Cycle counter increments every cycle and wraps FFFF to 0000. A clear write in the same cycle wins over the increment.
- Reset asserted mid-HOLD returns to IDLE. A `store` still high after reset release is treated as a new edge and writes once.
- Unmapped access sets `addr_err` on the same edge that would have performed the access.

## Structure
- Shared package: IO offsets (LED=0, SW=1, CYC=2, WCNT=3), FSM state encoding, word width 16.
- One sub-module, `ram_sp_wf`: single-port, write-first, synchronous-read RAM parameterised by depth. Decode, IO registers, FSM and counters stay in the top of this block.

## Test plan
- Write then read: drive bus=16'h1234 and addr=5, then `store`=1 for 1 cycle. Next cycle with addr=5 -> `rdata`=16'h1234 one cycle later; write counter=1.
- Stuck store: hold `store` high for 4 cycles at addr=6 while the bus changes every cycle. Exactly one write occurs, with the value from the bus the cycle before `store` rose; write counter increments by 1.
- LEDs: write 16'hFFFF to FFF0 -> `leds`=10'h3FF. Read FFF0 -> 16'h03FF. Set `sw`=10'h155 and read FFF1 -> 16'h0155.
- Counter: write to FFF2, read FFF2 three cycles later -> small known value, matched against the bench's own count. Force near FFFF and confirm wrap to 0.
- Unmapped: read addr 16'h0200 (DEPTH_LOG2=7) -> `rdata`=0, `addr_err`=1. A later write to 16'h0200 is dropped, RAM unchanged, `addr_err` stays 1.
- Reset mid-access: assert `Resetn`=0 during HOLD -> all outputs return to reset values. Release with `store` still high -> one write occurs. Previously written RAM words are retained.
